// File: rtl/dpram_arb_pkg.sv
// Shared helpers for the dpram round-robin arbiter: index width and one-hot decode.
package dpram_arb_pkg;

  // Index width for N requesters, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot to binary index (up to 16 requesters); an all-zero vector maps to 0.
  function automatic int onehot2idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dpram_rr_arbiter_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, search starts at ptr and wraps.
// ptr moves to one past the granted index; with no request it holds.
// Grants are forced to zero while rst is high.
module rr_arb
  import dpram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (~|gnt && req[i] && (i >= int'(ptr))) gnt[i] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (~|gnt && req[i]) gnt[i] = 1'b1;
      end
    end
    gnt_idx = IW'(onehot2idx(16'(gnt)));
  end

  // Pointer advances past the winner so it gets lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Shares one single-clock dpram (one read port, one write port) between NUM_REQ
// requesters with independent round-robin arbitration per port.
// Read data returns RD_LAT (0 or 1) cycles after the grant with a one-hot rd_vld.
// Optional build macro DPRAM_RR_ARBITER_RAW_BYPASS_EN: a same-cycle read and write
// to the same address returns the new write data instead of the old RAM contents.
// Handshake: a requester holds req until it sees its gnt bit in the same cycle;
// the grant cycle is the transfer cycle, there is no separate ready.
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    rd_req,
  input  logic [NUM_REQ*AW-1:0] rd_addr,
  output logic [NUM_REQ-1:0]    rd_gnt,
  output logic [NUM_REQ-1:0]    rd_vld,
  output logic [DW-1:0]         rd_data,
  input  logic [NUM_REQ-1:0]    wr_req,
  input  logic [NUM_REQ*AW-1:0] wr_addr,
  input  logic [NUM_REQ*DW-1:0] wr_data,
  output logic [NUM_REQ-1:0]    wr_gnt,
  output logic [AW-1:0]         ram_raddr,
  input  logic [DW-1:0]         ram_dout,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_waddr,
  output logic [DW-1:0]         ram_din
);

  localparam int IW = clog2_min1(NUM_REQ);

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [AW-1:0] raddr_q;

  rr_arb #(.N(NUM_REQ), .IW(IW)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  rr_arb #(.N(NUM_REQ), .IW(IW)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  // Read address follows the winner and otherwise parks on the last value.
  always_comb begin
    ram_raddr = raddr_q;
    if (rst) begin
      ram_raddr = '0;
    end else if (|rd_gnt) begin
      ram_raddr = rd_addr[int'(rd_idx)*AW +: AW];
    end
  end

  // Remember the last driven read address so an idle port does not toggle.
  always_ff @(posedge clk) begin
    if (rst) raddr_q <= '0;
    else     raddr_q <= ram_raddr;
  end

  // Write port is a straight mux of the granted requester.
  always_comb begin
    ram_we    = |wr_gnt;
    ram_waddr = '0;
    ram_din   = '0;
    if (|wr_gnt) begin
      ram_waddr = wr_addr[int'(wr_idx)*AW +: AW];
      ram_din   = wr_data[int'(wr_idx)*DW +: DW];
    end
  end

`ifdef DPRAM_RR_ARBITER_RAW_BYPASS_EN
  logic raw_hit;
  assign raw_hit = (|rd_gnt) && ram_we && (ram_raddr == ram_waddr);
`endif

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign rd_vld = rd_gnt;
`ifdef DPRAM_RR_ARBITER_RAW_BYPASS_EN
      assign rd_data = raw_hit ? ram_din : ram_dout;
`else
      assign rd_data = ram_dout;
`endif
    end else begin : g_lat1
      logic [NUM_REQ-1:0] tag_q;

      // Tag remembers who was granted so the returning data can be routed.
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= rd_gnt;
      end

      // A read granted just before reset must not surface while reset is high.
      assign rd_vld = rst ? '0 : tag_q;

`ifdef DPRAM_RR_ARBITER_RAW_BYPASS_EN
      logic          byp_hit_q;
      logic [DW-1:0] byp_data_q;

      // Write data captured alongside the tag for a same-address collision.
      always_ff @(posedge clk) begin
        if (rst) begin
          byp_hit_q  <= 1'b0;
          byp_data_q <= '0;
        end else begin
          byp_hit_q  <= raw_hit;
          byp_data_q <= ram_din;
        end
      end

      assign rd_data = byp_hit_q ? byp_data_q : ram_dout;
`else
      assign rd_data = ram_dout;
`endif
    end
  endgenerate

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Shares one dpram instance (one read port, one write port, single clock) between NUM_REQ requesters.
- Runs independent round-robin arbitration for the read port and for the write port.
- Routes read data back to the granted requester after the RAM read latency, with a per-requester valid pulse.
- Sits between the func_arbiter request logic and the dpram; drives dpram raddr/we/waddr/din and consumes dout.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, read latency of the attached dpram (0 or 1); must match the dpram rd_lat.

Ports:
- clk  in  1  single clock for the arbiter and the RAM (dpram rd_clk = wr_clk = clk).
- rst  in  1  synchronous, active-high reset.
- rd_req  in  NUM_REQ  per-requester read request; held until granted.
- rd_addr  in  NUM_REQ*AW  packed read addresses; requester i uses bits [i*AW +: AW].
- rd_gnt  out  NUM_REQ  one-hot read grant, combinational, same cycle as the request.
- rd_vld  out  NUM_REQ  one-hot pulse that qualifies rd_data.
- rd_data  out  DW  read data, broadcast to all requesters.
- wr_req  in  NUM_REQ  per-requester write request; held until granted.
- wr_addr  in  NUM_REQ*AW  packed write addresses.
- wr_data  in  NUM_REQ*DW  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant, combinational.
- ram_raddr  out  AW  to dpram raddr.
- ram_dout  in  DW  from dpram dout.
- ram_we  out  1  to dpram we.
- ram_waddr  out  AW  to dpram waddr.
- ram_din  out  DW  to dpram din.

Behaviour:
- Arbitration, per port (read and write handled identically):
  - Search starts at ptr, then ptr+1 … wraps to 0. The first asserted request is granted.
  - At most one grant per port per cycle.
  - On a grant to index g: ptr <= (g == NUM_REQ-1) ? 0 : g+1.
  - With no request, ptr holds and the grant is all zero.
- Read port:
  - ram_raddr = address of the granted requester. With no grant, ram_raddr holds its last value (no toggling).
  - RD_LAT=1: a one-hot tag register captures rd_gnt. Next cycle, rd_vld = tag and rd_data = ram_dout.
  - RD_LAT=0: rd_vld = rd_gnt and rd_data = ram_dout in the same cycle.
- Write port: ram_we = |wr_gnt; ram_waddr and ram_din are the granted requester's address and data.
- Back-to-back: a requester holding its request while it is the sole requester is granted every cycle. Throughput is 1 read + 1 write per cycle.
- Fairness: with all requesters continuously requesting, each is granted exactly once per NUM_REQ cycles on each port.
- Simultaneous read and write to the same address (feature off): read returns the pre-write data.
- Reset:
  - Both ptrs go to 0 and the read tag clears.
  - rd_vld = 0; rd_gnt and wr_gnt = 0 while rst is high; ram_we = 0; ram_raddr = 0; ram_waddr = 0; ram_din = 0.
  - Reset mid-operation: a read granted in the cycle before rst rises produces no rd_vld.
- rd_data is undefined when rd_vld is zero; the bench must not check it then.

Optional Feature:
- Macro: DPRAM_RR_ARBITER_RAW_BYPASS_EN.
- Defined:
  - Compare the granted read address against ram_waddr when ram_we is high in the same cycle.
  - On a match, rd_data at the rd_vld cycle = the written ram_din (registered alongside the tag when RD_LAT=1) instead of ram_dout.
  - Adds one AW-bit comparator and one DW+1-bit register.
- Undefined: no compare; rd_data is always ram_dout, giving old-data semantics.

Decomposition:
- Package dpram_arb_pkg holds:
  - function onehot2idx (one-hot to index);
  - localparam-style helper IDX_W = $clog2(NUM_REQ) (as a function clog2_min1 returning ≥1).
- Sub-module rr_arb (parameter N): inputs clk, rst, req[N]; outputs gnt[N] (one-hot, combinational) and gnt_idx. It owns ptr and is instantiated twice, once for reads and once for writes.

Test Plan:
- Single read, RD_LAT=1: preload addr 0x0010=0xA5; rd_req[2]=1 with addr 0x0010 → rd_gnt=0b0100 the same cycle; next cycle rd_vld=0b0100 and rd_data=0xA5.
- Fairness: NUM_REQ=4, all rd_req high for 8 cycles → rd_gnt sequence 1,2,4,8,1,2,4,8 (one-hot); each rd_vld lagging by 1 cycle.
- Write contention: wr_req=0b1010 with data 0x11 (req1) and 0x33 (req3), both to addr 5 → wr_gnt=0b0010 then 0b1000; a subsequent read of addr 5 returns 0x33.
- Same-cycle RAW on addr 7 (old 0x00, write 0x5C): with bypass off rd_data=0x00; with DPRAM_RR_ARBITER_RAW_BYPASS_EN defined, rd_data=0x5C.
- Reset mid-operation: grant rd_req[1], assert rst the next cycle → rd_vld stays 0; after release, first grant goes to the lowest active requester (ptr=0).
- RD_LAT=0 build: rd_req[0] on preloaded addr 3=0x7E → rd_gnt, rd_vld=0b0001 and rd_data=0x7E all in the same cycle.
